user_out_capture: RTL and testbench
===================================

# user_out_capture

Downstream capture stage for the tiny user design: samples the 8-bit output bus the user module drives on `io_out[27:20]`, records changes or periodic samples into a FIFO, and exposes them to the management SoC over the Wishbone slave port. Instantiated inside `user_project_wrapper` next to the user module; also raises an interrupt on FIFO fill level.

## Interface
- `FIFO_DEPTH`, 16: entries; power of two, 4..64.
- `BASE_ADDR`, 32'h3000_0000: block base; decode on `wbs_adr_i[31:4] == BASE_ADDR[31:4]`.
- `SYNC_STAGES`, 2: synchronizer flops on `user_out_i` (≥2).

- `wb_clk_i`  in  1  sole clock.
- `wb_rst_ni`  in  1  asynchronous, active-low reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe/cycle/write.
- `wbs_sel_i`  in  4  byte lanes (writes only).
- `wbs_adr_i`  in  32  address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  single-cycle ack.
- `wbs_dat_o`  out  32  read data.
- `user_out_i`  in  8  user module output bus (asynchronous to `wb_clk_i`).
- `irq_o`  out  1  level interrupt to `user_irq[0]`.

## Operation
- Registers (offset from base): 0x0 CTRL RW, 0x4 STATUS, 0x8 DATA RO-pop; 0xC unmapped (reads 0, writes ignored, still acked).
- CTRL: [0] EN, [1] MODE (0 = on change, 1 = periodic), [2] CLR (write-1, self-clearing, reads 0), [15:8] PERIOD, [23:16] THRESH. Writes honour `wbs_sel_i` per byte.
- CLR: flushes FIFO, clears OVF, zeroes timestamp and period counter in the same cycle.
- STATUS: [6:0] level (0..FIFO_DEPTH), [8] EMPTY, [9] FULL, [10] OVF sticky; writing 1 to bit 10 clears OVF; other bits read-only.
- Input path: `user_out_i` → SYNC_STAGES flops → `cur`; `prev` <= `cur` every cycle, including when EN=0.
- MODE 0 push: EN && `cur != prev`.
- MODE 1 push: EN && period counter == PERIOD; counter counts 0..PERIOD, then wraps to 0. PERIOD=0 pushes every cycle. Counter holds at 0 while EN=0.
- Entry: {ts[15:0], data[7:0]}; ts is a 16-bit counter, increments each cycle while EN, wraps 0xFFFF→0.
- DATA read: {ts, 7'b0, valid, data}. Valid=1 and pop if non-empty; if empty, returns 0 with no pop.
- Push while full: entry dropped, OVF set. Push and pop in the same cycle while full: both occur, level unchanged. Push and pop-read while empty: push occurs, read returns valid=0.
- `irq_o` registered = EN && THRESH≠0 && level ≥ THRESH.

## Timing
- Reset: `wbs_ack_o`=0, `wbs_dat_o`=0, `irq_o`=0, CTRL=0, FIFO empty, OVF=0, ts=0, sync/prev flops=0.
- Wishbone: on stb&cyc&hit&!ack, `wbs_ack_o`=1 and `wbs_dat_o` valid on the next edge for exactly one cycle. Back-to-back transfers ack every other cycle. Write and pop take effect on the ack edge. `wbs_dat_o` returns to 0 when ack is low.
- Capture latency: change at `user_out_i` → FIFO entry visible in STATUS level at SYNC_STAGES+2 edges.
- EN written 1: first periodic push occurs PERIOD+1 cycles after the ack edge.
- `irq_o` lags level by one cycle.
- Reset assertion mid-transfer: ack drops immediately; FIFO contents are lost.

## Configuration
- `OUTCAP_TIMESTAMP_EN` defined: ts counter and the 16-bit ts field in the FIFO are implemented; DATA[31:16] = ts.
- Undefined: no counter or ts storage; DATA[31:16] reads 0. All other behaviour is identical.

## Test plan
- Reset then read STATUS → 0x0000_0100 (EMPTY); DATA read → 0x0, level stays 0.
- CTRL=0x1, drive `user_out_i` 0x00→0xA5→0x3C, read DATA twice → data 0xA5 then 0x3C, valid=1, ts delta equals drive spacing (TIMESTAMP_EN); third read → valid=0.
- CTRL=0x0000_0403 (periodic, PERIOD=4), constant 0x5A for 50 cycles → level 10 (±1 at boundary); consecutive ts differ by 5.
- Fill 16 entries plus 3 extra pushes → FULL=1, OVF=1, level 16, first 16 values preserved; write STATUS bit10=1 → OVF=0.
- THRESH=4, MODE 0, 4 changes → `irq_o` rises one cycle after level hits 4; one DATA read → `irq_o` falls.
- Full FIFO with pop and push on the same edge → level stays 16, OVF unchanged; CLR write → level 0, ts 0; assert `wb_rst_ni` low mid-ack → `wbs_ack_o` 0 at once.

Source files
------------

// File: rtl/user_out_capture.sv
// user_out_capture: samples user_out_i into a FIFO readable over Wishbone, with fill-level irq; define OUTCAP_TIMESTAMP_EN to add a 16-bit timestamp per entry
module user_out_capture #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [7:0]  user_out_i,
  output logic        irq_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] cur, prev_q;
  logic en_q, en_d, mode_q, mode_d, ovf_q, ovf_d, ack_q, irq_q;
  logic [7:0] period_q, period_d, thresh_q, thresh_d, pcnt_q, pcnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] dat_q, rdata;
  logic [7:0] data_mem_q [FIFO_DEPTH];
  logic [15:0] rd_ts;
  logic [1:0] off;
  logic req, wr, rd, clr, ovf_clr, empty, full, push_req, do_push, do_pop;
  logic unused_ok;
  assign cur       = sync_q[SYNC_STAGES-1];
  assign off       = wbs_adr_i[3:2];
  assign req       = wbs_stb_i && wbs_cyc_i && !ack_q && wbs_adr_i[31:4] == BASE_ADDR[31:4];
  assign wr        = req && wbs_we_i;
  assign rd        = req && !wbs_we_i;
  assign clr       = wr && off == 2'd0 && wbs_sel_i[0] && wbs_dat_i[2];
  assign ovf_clr   = wr && off == 2'd1 && wbs_sel_i[1] && wbs_dat_i[10];
  assign empty     = count_q == '0;
  assign full      = count_q == CW'(FIFO_DEPTH);
  assign push_req  = en_q && (mode_q ? pcnt_q == period_q : cur != prev_q);
  assign do_pop    = rd && off == 2'd2 && !empty;
  assign do_push   = push_req && (!full || do_pop);
  assign rdata     = off == 2'd0 ? {8'd0, thresh_q, period_q, 6'd0, mode_q, en_q}
                   : off == 2'd1 ? {21'd0, ovf_q, full, empty, 1'b0, 7'(count_q)}
                   : off == 2'd2 ? (empty ? 32'd0 : {rd_ts, 7'd0, 1'b1, data_mem_q[rd_ptr_q]})
                   : 32'd0;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;
  assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i[31:24], wbs_dat_i[7:3], wbs_sel_i[3]};
  // next state for control fields, period counter, FIFO pointers and overflow flag
  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    period_d = period_q;
    thresh_d = thresh_q;
    if (wr && off == 2'd0) begin
      if (wbs_sel_i[0]) {mode_d, en_d} = wbs_dat_i[1:0];
      if (wbs_sel_i[1]) period_d = wbs_dat_i[15:8];
      if (wbs_sel_i[2]) thresh_d = wbs_dat_i[23:16];
    end
    pcnt_d   = (clr || !en_q || pcnt_q >= period_q) ? 8'd0 : pcnt_q + 8'd1;
    wr_ptr_d = clr ? '0 : do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = clr ? '0 : do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = clr ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    ovf_d    = !clr && ((push_req && !do_push) || (ovf_q && !ovf_clr));
  end
  // state registers, input synchronizer and registered Wishbone response
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      sync_q   <= '0;
      prev_q   <= '0;
      en_q     <= 1'b0;
      mode_q   <= 1'b0;
      period_q <= '0;
      thresh_q <= '0;
      pcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], user_out_i};
      prev_q   <= cur;
      en_q     <= en_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      thresh_q <= thresh_d;
      pcnt_q   <= pcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ack_q    <= req;
      dat_q    <= rd ? rdata : 32'd0;
      irq_q    <= en_q && thresh_q != 8'd0 && 8'(count_q) >= thresh_q;
    end
  // FIFO data storage; validity is tracked by the pointers so no reset is needed
  always_ff @(posedge wb_clk_i)
    if (do_push) data_mem_q[wr_ptr_q] <= cur;
`ifdef OUTCAP_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] ts_mem_q [FIFO_DEPTH];
  // capture timestamp advances only while enabled and restarts on CLR
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) ts_q <= '0;
    else ts_q <= clr ? 16'd0 : en_q ? ts_q + 16'd1 : ts_q;
  // timestamp half of each FIFO entry
  always_ff @(posedge wb_clk_i)
    if (do_push) ts_mem_q[wr_ptr_q] <= ts_q;
  assign rd_ts = ts_mem_q[rd_ptr_q];
`else
  assign rd_ts = 16'd0;
`endif
endmodule

// File: tb/tb_user_out_capture.sv
// tb_user_out_capture: directed table plus hand sequences for user_out_capture
module tb_user_out_capture;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic clk = 1'b0, rst_n = 1'b0, stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0] sel = 4'hF;
  logic [31:0] adr = BASE, wdat = '0, rdat;
  logic ack, irq;
  logic [7:0] uo = 8'h00;
  int errors = 0, checks = 0;

  user_out_capture dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .user_out_i(uo), .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  uo;
    int          gap;
    logic        we;
    logic [3:0]  off;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] mask;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb(input logic w, input logic [3:0] off, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] r);
    int n;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = BASE | 32'(off); wdat = d; sel = s;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
    if (!ack) begin
      checks++; errors++;
      $display("FAIL wb_ack: got no ack after %0d cycles required ack", n);
    end
    r = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] r;
    wb(1'b0, off, 32'h0, 4'hF, r);
    check(name, r, exp);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] r;
    wb(1'b1, off, d, 4'hF, r);
  endtask

  initial begin
    vec_t v[$];
    logic [31:0] r, prev_r;
    int acks;
    v.push_back(vec_t'{8'h00, 0, 1'b0, 4'h4, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0100});
    v.push_back(vec_t'{8'h00, 0, 1'b0, 4'h8, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000});
    v.push_back(vec_t'{8'h00, 0, 1'b0, 4'h4, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0100});
    v.push_back(vec_t'{8'h00, 0, 1'b1, 4'h0, 32'h1, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000});
    v.push_back(vec_t'{8'hA5, 6, 1'b0, 4'h4, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0001});
    v.push_back(vec_t'{8'h3C, 6, 1'b0, 4'h4, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0002});
    v.push_back(vec_t'{8'h3C, 0, 1'b0, 4'h8, 32'h0, 4'hF, 32'h0000_FFFF, 32'h0000_01A5});
    v.push_back(vec_t'{8'h3C, 0, 1'b0, 4'h8, 32'h0, 4'hF, 32'h0000_FFFF, 32'h0000_013C});
    v.push_back(vec_t'{8'h3C, 0, 1'b0, 4'h8, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000});
    v.push_back(vec_t'{8'h3C, 0, 1'b0, 4'h4, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0100});
    v.push_back(vec_t'{8'h3C, 0, 1'b0, 4'h0, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0001});
    v.push_back(vec_t'{8'h3C, 0, 1'b1, 4'h0, 32'h5, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000});
    v.push_back(vec_t'{8'h3C, 0, 1'b0, 4'h0, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0001});
    v.push_back(vec_t'{8'h3C, 0, 1'b1, 4'hC, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000});
    v.push_back(vec_t'{8'h3C, 0, 1'b0, 4'hC, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000});
    v.push_back(vec_t'{8'h3C, 0, 1'b1, 4'h0, 32'hFFFF_FF03, 4'h4, 32'hFFFF_FFFF, 32'h0000_0000});
    v.push_back(vec_t'{8'h3C, 0, 1'b0, 4'h0, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h00FF_0001});
    v.push_back(vec_t'{8'h3C, 0, 1'b1, 4'h0, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000});
    v.push_back(vec_t'{8'h3C, 0, 1'b0, 4'h0, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000});
    v.push_back(vec_t'{8'h3C, 0, 1'b0, 4'h4, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0100});

    repeat (2) @(posedge clk);
    #1;
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_dat", rdat, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    foreach (v[i]) begin
      uo = v[i].uo;
      repeat (v[i].gap) @(posedge clk);
      wb(v[i].we, v[i].off, v[i].wd, v[i].sel, r);
      check($sformatf("vec%0d", i), r & v[i].mask, v[i].exp);
    end

    // first periodic push lands PERIOD+1 edges after the enabling ack
    wr(4'h0, 32'h0000_0203);
    rd_chk("per2_before", 4'h4, 32'h0000_0100);
    rd_chk("per2_first", 4'h4, 32'h0000_0001);
    wr(4'h0, 32'h0000_0004);
    rd_chk("clr_off", 4'h4, 32'h0000_0100);

    // periodic PERIOD=4 for 50 cycles
    wr(4'h0, 32'h0000_0403);
    uo = 8'h5A;
    repeat (50) @(posedge clk);
    rd_chk("per4_level", 4'h4, 32'h0000_000A);
    wr(4'h0, 32'h0000_0000);
    prev_r = '0;
    for (int i = 0; i < 10; i++) begin
      wb(1'b0, 4'h8, 32'h0, 4'hF, r);
      check($sformatf("per4_data%0d", i), r & 32'hFFFF, 32'h015A);
`ifdef OUTCAP_TIMESTAMP_EN
      if (i > 0) check($sformatf("per4_ts%0d", i), 32'(16'(r[31:16] - prev_r[31:16])), 32'd5);
`endif
      prev_r = r;
    end
    rd_chk("per4_empty", 4'h4, 32'h0000_0100);

    // fill past full
    wr(4'h0, 32'h0000_0005);
    for (int i = 1; i <= 19; i++) begin
      @(posedge clk); #1 uo = 8'(i);
      repeat (2) @(posedge clk);
    end
    repeat (4) @(posedge clk);
    rd_chk("full_ovf", 4'h4, 32'h0000_0610);
    check("full_irq", 32'(irq), 32'h0);
    wr(4'h4, 32'h0000_0400);
    rd_chk("ovf_cleared", 4'h4, 32'h0000_0210);
    @(posedge clk); #1 uo = 8'hEE;
    @(posedge clk);
    wb(1'b0, 4'h8, 32'h0, 4'hF, r);
    check("pushpop_data", r & 32'hFFFF, 32'h0101);
    rd_chk("pushpop_status", 4'h4, 32'h0000_0210);
    for (int i = 2; i <= 17; i++) begin
      wb(1'b0, 4'h8, 32'h0, 4'hF, r);
      check($sformatf("drain%0d", i), r & 32'hFFFF, i == 17 ? 32'h01EE : 32'h0100 | 32'(i));
    end
    rd_chk("drain_empty_data", 4'h8, 32'h0);
    rd_chk("drain_empty_status", 4'h4, 32'h0000_0100);

    // irq at threshold 4
    wr(4'h0, 32'h0004_0005);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1 uo = 8'(8'h11 * i);
      repeat (2) @(posedge clk);
    end
    @(posedge clk); #1 uo = 8'h44;
    repeat (3) @(posedge clk);
    #1 check("irq_level_edge", 32'(irq), 32'h0);
    @(posedge clk); #1 check("irq_rise", 32'(irq), 32'h1);
    wb(1'b0, 4'h8, 32'h0, 4'hF, r);
    check("irq_pop_data", r & 32'hFFFF, 32'h0111);
    check("irq_hold", 32'(irq), 32'h1);
    @(posedge clk); #1 check("irq_fall", 32'(irq), 32'h0);

    // CLR flushes and restarts the timestamp
    wr(4'h0, 32'h0000_0005);
    @(posedge clk); #1 uo = 8'h77;
    repeat (4) @(posedge clk);
`ifdef OUTCAP_TIMESTAMP_EN
    rd_chk("clr_ts_data", 4'h8, 32'h0003_0177);
`else
    rd_chk("clr_ts_data", 4'h8, 32'h0000_0177);
`endif
    rd_chk("clr_status", 4'h4, 32'h0000_0100);

    // back-to-back strobe acks every other cycle; dat returns to 0
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'h4;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    stb = 1'b0; cyc = 1'b0;
    check("b2b_acks", 32'(acks), 32'd2);
    @(posedge clk); #1;
    check("idle_dat", rdat, 32'h0);

    // non-matching addresses never ack
    adr = BASE | 32'h10; stb = 1'b1; cyc = 1'b1;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    adr = 32'h2000_0004;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    stb = 1'b0; cyc = 1'b0;
    check("miss_acks", 32'(acks), 32'd0);

    // reset in the middle of an ack
    uo = 8'h99;
    repeat (5) @(posedge clk);
    #1 stb = 1'b1; cyc = 1'b1; adr = BASE | 32'h4;
    @(posedge clk); #1;
    check("midack_ack", 32'(ack), 32'h1);
    check("midack_level", rdat, 32'h0000_0001);
    rst_n = 1'b0;
    #1;
    check("rst_ack_drop", 32'(ack), 32'h0);
    check("rst_dat_drop", rdat, 32'h0);
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    rd_chk("post_rst_status", 4'h4, 32'h0000_0100);
    rd_chk("post_rst_ctrl", 4'h0, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
